// File: rtl/ram_arbiter_pkg.sv
// Shared types for the two-client single-port RAM arbiter (optional RAM_ARBITER_TIMEOUT_EN).
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic CLIENT0 = 1'b0;
    localparam logic CLIENT1 = 1'b1;

endpackage

// File: rtl/ram_arbiter_rr_select_2.sv
// Combinational two-way round-robin pick: a lone requester wins, a tie goes to the client not granted last.
module rr_select_2
    import ram_arbiter_pkg::*;
(
    input  logic c0_request,
    input  logic c1_request,
    input  logic last_grant,
    output logic grant,
    output logic grant_valid
);

    always_comb begin
        grant_valid = c0_request | c1_request;
        grant       = CLIENT0;
        if (c0_request && c1_request) begin
            grant = (last_grant == CLIENT0) ? CLIENT1 : CLIENT0;
        end else if (c1_request) begin
            grant = CLIENT1;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-client arbiter in front of a single-port RAM; define RAM_ARBITER_TIMEOUT_EN to bound the WAIT state.
// Handshake: cN_request is a level held until cN_ready; cN_ready is a one-cycle completion pulse.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int DEPTH          = 256,
    parameter int TIMEOUT_CYCLES = 15,
    localparam int ADDR_W        = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              c0_request,
    input  logic              c0_write_enable,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [WIDTH-1:0]  c0_write_data,
    output logic [WIDTH-1:0]  c0_read_data,
    output logic              c0_ready,
    input  logic              c1_request,
    input  logic              c1_write_enable,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [WIDTH-1:0]  c1_write_data,
    output logic [WIDTH-1:0]  c1_read_data,
    output logic              c1_ready,
    output logic              ram_request,
    output logic              ram_write_enable,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [WIDTH-1:0]  ram_write_data,
    input  logic [WIDTH-1:0]  ram_read_data,
    input  logic              ram_ready,
    output logic              timeout_error,
    output logic [1:0]        fsm_state
);

    state_t state;
    logic   last_grant;
    logic   granted;
    logic   pick;
    logic   pick_valid;

    rr_select_2 u_select (
        .c0_request  (c0_request),
        .c1_request  (c1_request),
        .last_grant  (last_grant),
        .grant       (pick),
        .grant_valid (pick_valid)
    );

    assign fsm_state = state;

`ifdef RAM_ARBITER_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] timer;
`else
    wire unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout_error = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            last_grant       <= CLIENT1;
            granted          <= CLIENT0;
            ram_request      <= 1'b0;
            ram_write_enable <= 1'b0;
            ram_addr         <= '0;
            ram_write_data   <= '0;
            c0_read_data     <= '0;
            c1_read_data     <= '0;
            c0_ready         <= 1'b0;
            c1_ready         <= 1'b0;
`ifdef RAM_ARBITER_TIMEOUT_EN
            timer            <= '0;
            timeout_error    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        granted          <= pick;
                        ram_write_enable <= (pick == CLIENT1) ? c1_write_enable : c0_write_enable;
                        ram_addr         <= (pick == CLIENT1) ? c1_addr : c0_addr;
                        ram_write_data   <= (pick == CLIENT1) ? c1_write_data : c0_write_data;
                        ram_request      <= 1'b1;
                        state            <= ISSUE;
                    end
                end
                ISSUE: begin
                    ram_request <= 1'b0;
`ifdef RAM_ARBITER_TIMEOUT_EN
                    timer       <= '0;
`endif
                    state       <= WAIT;
                end
                WAIT: begin
                    if (ram_ready) begin
                        if (!ram_write_enable) begin
                            if (granted == CLIENT1) c1_read_data <= ram_read_data;
                            else                    c0_read_data <= ram_read_data;
                        end
                        c0_ready <= (granted == CLIENT0);
                        c1_ready <= (granted == CLIENT1);
                        state    <= DONE;
`ifdef RAM_ARBITER_TIMEOUT_EN
                    end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                        // RAM never answered: complete the client without touching its read data.
                        c0_ready      <= (granted == CLIENT0);
                        c1_ready      <= (granted == CLIENT1);
                        timeout_error <= 1'b1;
                        state         <= DONE;
                    end else begin
                        timer <= timer + 1'b1;
`endif
                    end
                end
                DONE: begin
                    c0_ready   <= 1'b0;
                    c1_ready   <= 1'b0;
                    last_grant <= granted;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a one-cycle RAM model; covers RAM_ARBITER_TIMEOUT_EN either way.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       c0_request, c0_write_enable, c1_request, c1_write_enable;
    logic [7:0] c0_addr, c0_write_data, c1_addr, c1_write_data;
    logic [7:0] c0_read_data, c1_read_data;
    logic       c0_ready, c1_ready;
    logic       ram_request, ram_write_enable, ram_ready;
    logic [7:0] ram_addr, ram_write_data, ram_read_data;
    logic       timeout_error;
    logic [1:0] fsm_state;

    logic [7:0] mem [256];
    logic       ram_hold;

    int n_tests = 0;
    int n_fail  = 0;
    int c0_ready_cnt = 0;
    int c1_ready_cnt = 0;
    int ram_req_cnt  = 0;
    logic [0:0] grant_log[$];
    logic [0:0] exp_q[$];

    ram_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .c0_request(c0_request), .c0_write_enable(c0_write_enable), .c0_addr(c0_addr),
        .c0_write_data(c0_write_data), .c0_read_data(c0_read_data), .c0_ready(c0_ready),
        .c1_request(c1_request), .c1_write_enable(c1_write_enable), .c1_addr(c1_addr),
        .c1_write_data(c1_write_data), .c1_read_data(c1_read_data), .c1_ready(c1_ready),
        .ram_request(ram_request), .ram_write_enable(ram_write_enable), .ram_addr(ram_addr),
        .ram_write_data(ram_write_data), .ram_read_data(ram_read_data), .ram_ready(ram_ready),
        .timeout_error(timeout_error), .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // one-cycle RAM: answers the cycle after ram_request unless held off
    always @(posedge clk) begin
        ram_ready <= ram_request && !ram_hold;
        if (ram_request) begin
            if (ram_write_enable) mem[ram_addr] <= ram_write_data;
            else                  ram_read_data <= mem[ram_addr];
        end
    end

    always @(negedge clk) begin
        if (c0_ready) begin c0_ready_cnt++; grant_log.push_back(1'b0); end
        if (c1_ready) begin c1_ready_cnt++; grant_log.push_back(1'b1); end
        if (ram_request) ram_req_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int cl, input logic req, input logic we,
                         input logic [7:0] addr, input logic [7:0] wd);
        if (cl == 0) begin
            c0_request = req; c0_write_enable = we; c0_addr = addr; c0_write_data = wd;
        end else begin
            c1_request = req; c1_write_enable = we; c1_addr = addr; c1_write_data = wd;
        end
    endtask

    // lat counts negedges from request until the client's ready is seen; -1 if never
    task automatic run_txn(input int cl, input logic we, input logic [7:0] addr,
                           input logic [7:0] wd, input int max_cyc, output int lat);
        lat = -1;
        drive(cl, 1'b1, we, addr, wd);
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clk); #1;
            if ((cl == 0 && c0_ready) || (cl == 1 && c1_ready)) begin
                lat = i;
                break;
            end
        end
        drive(cl, 1'b0, we, addr, wd);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int c0_before, c1_before, req_before;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'hA5;
        ram_hold = 1'b0;
        reset_n  = 1'b0;
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
        #2;
        check("reset_outputs", {ram_request, ram_write_enable, ram_addr, ram_write_data,
              c0_ready, c1_ready, c0_read_data, c1_read_data, timeout_error, fsm_state}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // single read by client 0
        req_before = ram_req_cnt;
        drive(0, 1'b1, 1'b0, 8'h10, 8'h00);
        @(negedge clk); #1;
        check("issue_req", ram_request, 1'b1);
        check("issue_addr", ram_addr, 8'h10);
        check("issue_we", ram_write_enable, 1'b0);
        @(negedge clk); #1;
        check("req_one_cycle", ram_request, 1'b0);
        check("early_ready", c0_ready, 1'b0);
        @(negedge clk); #1;
        check("read_ready", c0_ready, 1'b1);
        check("read_data", c0_read_data, 8'hA5);
        drive(0, 1'b0, 1'b0, 8'h10, 8'h00);
        @(negedge clk); #1;
        check("ready_pulse_ends", c0_ready, 1'b0);
        check("read_data_hold", c0_read_data, 8'hA5);
        check("ram_req_count", ram_req_cnt - req_before, 1);

        // client 1 write then read
        repeat (2) @(negedge clk);
        c0_before = c0_ready_cnt;
        run_txn(1, 1'b1, 8'h20, 8'h3C, 10, lat);
        check("write_lat", lat, 3);
        check("write_mem", mem[8'h20], 8'h3C);
        check("write_keeps_rdata", c1_read_data, 8'h00);
        repeat (2) @(negedge clk);
        run_txn(1, 1'b0, 8'h20, 8'h00, 10, lat);
        check("readback_lat", lat, 3);
        check("readback_data", c1_read_data, 8'h3C);
        check("c0_rdata_untouched", c0_read_data, 8'hA5);
        check("no_c0_ready", c0_ready_cnt - c0_before, 0);

        // non-granted client's fields change mid-transaction
        repeat (2) @(negedge clk);
        drive(0, 1'b1, 1'b0, 8'h10, 8'h00);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk); #1;
            c1_addr = 8'(i * 37); c1_write_data = 8'(i); c1_write_enable = 1'(i);
            if (c0_ready) break;
            check("stable_addr", ram_addr, 8'h10);
            check("stable_we", ram_write_enable, 1'b0);
        end
        drive(0, 1'b0, 1'b0, 8'h10, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);

        // contention right after reset: strict alternation starting with client 0
        do_reset();
        grant_log.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(1'(i));
        drive(0, 1'b1, 1'b0, 8'h10, 8'h00);
        drive(1, 1'b1, 1'b0, 8'h20, 8'h00);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (grant_log.size() >= 8) break;
        end
        drive(0, 1'b0, 1'b0, 8'h10, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h20, 8'h00);
        check("contention_count", grant_log.size(), 8);
        for (int i = 0; i < 8 && grant_log.size() > 0; i++) begin
            check("grant_order", grant_log.pop_front(), exp_q.pop_front());
        end
        exp_q.delete();
        check("contention_c0_data", c0_read_data, 8'hA5);
        check("contention_c1_data", c1_read_data, 8'h3C);

        // reset while waiting on the RAM
        repeat (3) @(negedge clk);
        ram_hold = 1'b1;
        c1_before = c1_ready_cnt;
        drive(1, 1'b1, 1'b0, 8'h20, 8'h00);
        repeat (2) @(negedge clk);
        #1;
        check("in_wait", fsm_state, 2'd2);
        reset_n = 1'b0;
        #1;
        check("midop_reset_outputs", {ram_request, ram_write_enable, ram_addr, ram_write_data,
              c0_ready, c1_ready, c0_read_data, c1_read_data, timeout_error, fsm_state}, 64'd0);
        drive(1, 1'b0, 1'b0, 8'h20, 8'h00);
        ram_hold = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("no_abandoned_ready", c1_ready_cnt - c1_before, 0);
        grant_log.delete();
        drive(0, 1'b1, 1'b0, 8'h10, 8'h00);
        drive(1, 1'b1, 1'b0, 8'h20, 8'h00);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (grant_log.size() >= 1) break;
        end
        drive(0, 1'b0, 1'b0, 8'h10, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h20, 8'h00);
        check("post_reset_grants", grant_log.size() >= 1, 1'b1);
        if (grant_log.size() >= 1) check("post_reset_tie", grant_log.pop_front(), 1'b0);

        // RAM never answers
        repeat (3) @(negedge clk);
        do_reset();
        ram_hold = 1'b1;
`ifdef RAM_ARBITER_TIMEOUT_EN
        run_txn(0, 1'b0, 8'h10, 8'h00, 40, lat);
        check("timeout_lat", lat, 17);
        check("timeout_flag", timeout_error, 1'b1);
        check("timeout_rdata", c0_read_data, 8'h00);
        repeat (5) @(negedge clk);
        #1;
        check("timeout_sticky", timeout_error, 1'b1);
        do_reset();
        check("timeout_cleared", timeout_error, 1'b0);
`else
        c0_before = c0_ready_cnt;
        run_txn(0, 1'b0, 8'h10, 8'h00, 100, lat);
        check("no_timeout_lat", lat, -1);
        check("no_timeout_ready", c0_ready_cnt - c0_before, 0);
        check("still_waiting", fsm_state, 2'd2);
        check("timeout_flag_zero", timeout_error, 1'b0);
        do_reset();
`endif
        ram_hold = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width.
REQ-002 SHALL have parameter DEPTH, default 256, word count; address width ADDR_W = $clog2(DEPTH).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 15, WAIT-state limit (used only with the timeout feature).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous and active-low.
REQ-006 cN_request  input  1  client N (N=0,1) transaction request, level, held until cN_ready.
REQ-007 cN_write_enable  input  1  client N: 1 = write, 0 = read.
REQ-008 cN_addr  input  ADDR_W  client N word address.
REQ-009 cN_write_data  input  WIDTH  client N write data.
REQ-010 cN_read_data  output  WIDTH  client N read result, valid while cN_ready=1.
REQ-011 cN_ready  output  1  client N one-cycle completion pulse.
REQ-012 ram_request, ram_write_enable, ram_addr, ram_write_data  output  1/1/ADDR_W/WIDTH  to the single-port RAM.
REQ-013 ram_read_data  input  WIDTH, and ram_ready  input  1, from the single-port RAM.
REQ-014 timeout_error  output  1  sticky RAM no-response flag.

Function
REQ-015 FSM states: IDLE, ISSUE, WAIT, DONE; all outputs registered.
REQ-016 IDLE: if no cN_request, stay; otherwise grant a client, latch its write_enable/addr/write_data, go ISSUE.
REQ-017 Grant: single requester wins; both requesting -> client other than last_grant wins (round-robin).
REQ-018 ISSUE: ram_request=1 with latched fields for exactly one cycle, then go WAIT; ram_request=0 in every other state.
REQ-019 WAIT: on ram_ready=1, go DONE; for a read, capture ram_read_data into granted cN_read_data on that edge.
REQ-020 DONE: granted cN_ready=1 for exactly this cycle, last_grant updated, then go IDLE; no new grant from DONE.
REQ-021 Latency: request sampled on edge e0, ram_request high in cycle e0..e1, cN_ready high in cycle e2..e3 with a one-cycle RAM; next grant no earlier than edge e3.
REQ-022 Clients SHALL deassert request no later than the edge ending their ready cycle; request seen in IDLE after DONE is treated as new.
REQ-023 cN_read_data SHALL hold its last value until the next read completion for that client; writes leave it unchanged.
REQ-024 Non-granted client's request, address and data changes SHALL have no effect on the transaction in flight.
REQ-025 ram_ready in IDLE/ISSUE/DONE SHALL be ignored.

Reset
REQ-026 reset_n=0 SHALL immediately force IDLE, all outputs 0, cN_read_data 0, last_grant=1 (client 0 wins first tie), timeout counter 0, timeout_error 0.
REQ-027 Reset mid-transaction SHALL abandon it with no cN_ready pulse; first post-reset grant follows REQ-016/017.

Configuration
REQ-028 Macro RAM_ARBITER_TIMEOUT_EN defined: WAIT counts cycles; if ram_ready absent for TIMEOUT_CYCLES cycles, go DONE, pulse granted cN_ready, leave cN_read_data unchanged, set timeout_error until reset.
REQ-029 Macro undefined: no counter, WAIT indefinitely, timeout_error tied 0.

Structure
REQ-030 Package ram_arbiter_pkg SHALL hold the state enum (IDLE/ISSUE/WAIT/DONE) and client index constants CLIENT0=0, CLIENT1=1.
REQ-031 One sub-module rr_select_2: combinational 2-way round-robin pick from (c0_request, c1_request, last_grant) -> grant index, grant valid.

Verification
REQ-032 Single read: preload RAM[0x10]=0xA5, c0 read 0x10 -> ram_request one cycle with ram_addr 0x10, c0_ready pulse 3 cycles after request edge, c0_read_data=0xA5.
REQ-033 Write then read: c1 writes 0x3C to 0x20, then reads 0x20 -> c1_read_data=0x3C, c0_ready never pulses.
REQ-034 Contention: both request continuously after reset -> grants strictly alternate c0,c1,c0,c1 over 8 transactions.
REQ-035 Reset mid-op: reset_n low during WAIT -> all outputs 0 immediately, no cN_ready pulse, next tie granted to c0.
REQ-036 With RAM_ARBITER_TIMEOUT_EN, RAM ready stuck 0 -> cN_ready after 15 WAIT cycles, timeout_error=1 held until reset; without macro, no pulse after 100 cycles.
REQ-037 Stability: change c1_addr during c0 transaction -> ram_addr unchanged until c0_ready.
